// File: rtl/game_health_tracker.sv
// game_health_tracker: character/health game state with saturating damage/heal, i-frames and optional passive regen (HEALTH_REGEN_EN)
module game_health_tracker #(
  parameter int MAX_HEALTH    = 10,
  parameter int IFRAME_CYCLES = 50000000,
  parameter int REGEN_CYCLES  = 200000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] char_sel,
  input  logic       char_sel_valid,
  input  logic       start,
  input  logic       damage_valid,
  input  logic [3:0] damage_amt,
  input  logic       heal_valid,
  input  logic [3:0] heal_amt,
  output logic [6:0] data,
  output logic       invuln,
  output logic       dead,
  output logic [1:0] game_state
);
  localparam int IW = $clog2(IFRAME_CYCLES + 1);
  localparam logic [3:0] MAXH = 4'(MAX_HEALTH);
  typedef enum logic [1:0] {IDLE, ALIVE, IFRAME, DEAD} state_t;
  state_t state, state_n;
  logic [1:0] char_reg, char_n;
  logic [3:0] health_reg, health_n, healed, damaged;
  logic [4:0] heal_sum;
  logic [IW-1:0] timer, timer_n;
  logic hit, regen_tick;
  always_comb begin
    heal_sum = {1'b0, health_reg} + {1'b0, heal_amt};
    healed = heal_sum > {1'b0, MAXH} ? MAXH : heal_sum[3:0];
    damaged = damage_amt >= health_reg ? 4'd0 : health_reg - damage_amt;
    hit = state == ALIVE && damage_valid && damage_amt != 4'd0;
    state_n = state;
    char_n = char_reg;
    health_n = health_reg;
    timer_n = timer;
    case (state)
      IDLE: begin
        char_n = char_sel_valid ? char_sel : char_reg;
        health_n = MAXH;
        state_n = start ? ALIVE : IDLE;
      end
      ALIVE: begin
        health_n = hit ? damaged : heal_valid ? healed : regen_tick ? health_reg + 4'd1 : health_reg;
        state_n = !hit ? ALIVE : damaged == 4'd0 ? DEAD : IFRAME;
        timer_n = hit ? IW'(IFRAME_CYCLES - 1) : timer;
      end
      IFRAME: begin
        health_n = heal_valid ? healed : health_reg;
        timer_n = timer == '0 ? '0 : timer - IW'(1);
        state_n = timer == '0 ? ALIVE : IFRAME;
      end
      default: begin
        health_n = start ? MAXH : 4'd0;
        state_n = start ? IDLE : DEAD;
      end
    endcase
  end
`ifdef HEALTH_REGEN_EN
  localparam int RW = $clog2(REGEN_CYCLES + 1);
  logic [RW-1:0] regen_cnt;
  logic regen_run;
  // any heal or hit in the cycle pre-empts and restarts the regen interval
  assign regen_run = state == ALIVE && !hit && !heal_valid && health_reg != 4'd0 && health_reg < MAXH;
  assign regen_tick = regen_run && regen_cnt == RW'(REGEN_CYCLES - 1);
  always_ff @(posedge clk)
    if (reset || !regen_run || regen_tick) regen_cnt <= '0;
    else regen_cnt <= regen_cnt + RW'(1);
`else
  assign regen_tick = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      char_reg <= 2'b00;
      health_reg <= MAXH;
      timer <= '0;
      data <= {3'b000, MAXH};
      invuln <= 1'b0;
      dead <= 1'b0;
      game_state <= IDLE;
    end else begin
      state <= state_n;
      char_reg <= char_n;
      health_reg <= health_n;
      timer <= timer_n;
      data <= {1'b0, char_n, health_n};
      invuln <= state_n == IFRAME;
      dead <= state_n == DEAD;
      game_state <= state_n;
    end
  end
endmodule

// File: tb/tb_game_health_tracker.sv
// tb_game_health_tracker: directed literal checks plus randomized run against a behavioural health model
module tb_game_health_tracker;
  localparam int MAXH = 10, IFR = 4, RGN = 8;
  logic clk = 0, reset = 1, char_sel_valid = 0, start = 0, damage_valid = 0, heal_valid = 0;
  logic [1:0] char_sel = 0;
  logic [3:0] damage_amt = 0, heal_amt = 0;
  logic [6:0] data;
  logic invuln, dead;
  logic [1:0] game_state;
  int n_tests = 0, n_fail = 0;
  bit cmp_en = 0;
  int m_phase = 0, m_h = MAXH, m_char = 0, m_left = 0, m_regen = 0;

  game_health_tracker #(.MAX_HEALTH(MAXH), .IFRAME_CYCLES(IFR), .REGEN_CYCLES(RGN)) dut (
    .clk(clk), .reset(reset), .char_sel(char_sel), .char_sel_valid(char_sel_valid), .start(start),
    .damage_valid(damage_valid), .damage_amt(damage_amt), .heal_valid(heal_valid), .heal_amt(heal_amt),
    .data(data), .invuln(invuln), .dead(dead), .game_state(game_state));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // phases: 0 idle, 1 alive, 2 invulnerable (m_left cycles remaining), 3 dead
  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_h = MAXH; m_char = 0; m_left = 0; m_regen = 0;
    end else if (m_phase == 0) begin
      if (char_sel_valid) m_char = char_sel;
      if (start) m_phase = 1;
    end else if (m_phase == 1) begin
      if (damage_valid && damage_amt != 0) begin
        m_h = (m_h > damage_amt) ? m_h - damage_amt : 0;
        m_regen = 0;
        if (m_h == 0) m_phase = 3;
        else begin m_phase = 2; m_left = IFR; end
      end else if (heal_valid) begin
        m_h = (m_h + heal_amt > MAXH) ? MAXH : m_h + heal_amt;
        m_regen = 0;
      end else begin
`ifdef HEALTH_REGEN_EN
        if (m_h < MAXH) begin
          m_regen++;
          if (m_regen == RGN) begin m_h++; m_regen = 0; end
        end else m_regen = 0;
`endif
      end
    end else if (m_phase == 2) begin
      if (heal_valid) m_h = (m_h + heal_amt > MAXH) ? MAXH : m_h + heal_amt;
      m_left--;
      if (m_left == 0) m_phase = 1;
    end else if (start) begin
      m_phase = 0; m_h = MAXH;
    end
  end

  always @(negedge clk)
    if (cmp_en) begin
      chk("model_data", data, {1'b0, 2'(m_char), 4'(m_h)});
      chk("model_state", game_state, m_phase);
      chk("model_flags", {invuln, dead}, {m_phase == 2, m_phase == 3});
    end

  task automatic step(input bit cs, input int ch, input bit st, input bit dv, input int da, input bit hv, input int ha);
    char_sel_valid = cs; char_sel = 2'(ch); start = st;
    damage_valid = dv; damage_amt = 4'(da); heal_valid = hv; heal_amt = 4'(ha);
    @(negedge clk);
    char_sel_valid = 0; start = 0; damage_valid = 0; heal_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    idle(2);
    cmp_en = 1;
    chk("reset_data", data, 7'h0A);
    chk("reset_state", {game_state, invuln, dead}, 4'b0000);
    reset = 0;
    step(1, 2, 1, 0, 0, 0, 0);
    chk("start_data", data, 7'h2A);
    chk("start_state", {game_state, invuln}, 3'b010);
    step(0, 0, 0, 1, 3, 0, 0);
    chk("hit3_health", data[3:0], 7);
    chk("hit3_invuln", invuln, 1);
    step(0, 0, 0, 1, 5, 0, 0);
    chk("iframe_dmg_ignored", data[3:0], 7);
    idle(2);
    chk("iframe_last_cycle", invuln, 1);
    idle(1);
    chk("iframe_over", {game_state, invuln}, 3'b010);
    step(0, 0, 0, 0, 0, 1, 9);
    chk("heal_saturate", data[3:0], 10);
    step(0, 0, 0, 1, 15, 0, 0);
    chk("dead_data", data, 7'h20);
    chk("dead_state", {game_state, dead}, 3'b111);
    step(0, 0, 0, 0, 0, 1, 4);
    chk("dead_heal_ignored", data[3:0], 0);
    step(1, 1, 1, 0, 0, 0, 0);
    chk("dead_to_idle", data, 7'h2A);
    chk("dead_to_idle_state", game_state, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 1, 2);
    chk("dmg_beats_heal", data[3:0], 8);
    idle(IFR);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("char_locked", data, 7'h28);
    step(0, 0, 0, 1, 1, 0, 0);
    chk("hit1_iframe", {game_state, data[3:0]}, 6'h27);
    reset = 1;
    @(negedge clk);
    chk("reset_mid_iframe", {data, game_state, invuln}, 10'h0A << 3);
    reset = 0;
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 0, 0);
    idle(IFR);
    chk("back_alive_h8", {game_state, data[3:0]}, 6'h18);
`ifdef HEALTH_REGEN_EN
    idle(RGN);
    chk("regen_h9", data[3:0], 9);
    idle(RGN);
    chk("regen_h10", data[3:0], 10);
    idle(20);
    chk("regen_hold", data[3:0], 10);
`else
    idle(100);
    chk("no_regen_h8", data[3:0], 8);
`endif
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 299) == 0;
      step($urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 6),
           $urandom_range(0, 3) == 0, $urandom_range(0, 15));
    end
    reset = 0;
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
